// File: rtl/parity_check_pipe.sv
// Two-stage pipelined parity checker for XNOR-parity-protected words.
// Stage 1 captures the word and the XNOR reduction of each half. Stage 2
// combines the halves, compares the result with the stored parity bit and
// drives the registered outputs. A sticky flag and a saturating counter
// record erroneous words as they leave the block.
module parity_check_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_par,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  input  logic             clr_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int HALF = WIDTH / 2;

  // XNOR reduction: 1 when the slice holds an even number of ones
  function automatic logic xnor_lo(input logic [WIDTH-1:0] d);
    return ~(^d[HALF-1:0]);
  endfunction

  function automatic logic xnor_hi(input logic [WIDTH-1:0] d);
    return ~(^d[WIDTH-1:HALF]);
  endfunction

  // Combine half reductions; mismatch against stored parity is an error
  function automatic logic par_err(input logic lo, input logic hi, input logic par);
    return (~(lo ^ hi)) ^ par;
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q,  s1_data_d;
  logic             s1_par_q,   s1_par_d;
  logic             s1_lo_q,    s1_lo_d;
  logic             s1_hi_q,    s1_hi_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q,  s2_data_d;
  logic             s2_err_q,   s2_err_d;
  logic             sticky_q,   sticky_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  logic s2_adv_s;
  logic s1_adv_s;
  logic err_xfer_s;

  // Handshake: a stage may load when it is empty or its contents move on
  always_comb begin
    s2_adv_s   = ~s2_valid_q | out_ready;
    s1_adv_s   = ~s1_valid_q | s2_adv_s;
    err_xfer_s = s2_valid_q & out_ready & s2_err_q;
  end

  assign in_ready   = s1_adv_s;
  assign out_valid  = s2_valid_q;
  assign out_data   = s2_data_q;
  assign out_err    = s2_err_q;
  assign err_sticky = sticky_q;
  assign err_cnt    = cnt_q;

  // Stage 1 next state: capture word and per-half reductions on accept
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_par_d   = s1_par_q;
    s1_lo_d    = s1_lo_q;
    s1_hi_d    = s1_hi_q;
    if (s1_adv_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_par_d  = in_par;
        s1_lo_d   = xnor_lo(in_data);
        s1_hi_d   = xnor_hi(in_data);
      end else begin
        s1_data_d = s1_data_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2 next state: finish the parity check; holds while stalled
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_err_d   = s2_err_q;
    if (s2_adv_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = s1_data_q;
        s2_err_d  = par_err(s1_lo_q, s1_hi_q, s1_par_q);
      end else begin
        s2_err_d  = s2_err_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Error accounting at the output transfer; a clear request takes priority
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (clr_err) begin
      sticky_d = 1'b0;
      cnt_d    = {CNT_W{1'b0}};
    end else if (err_xfer_s) begin
      sticky_d = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      sticky_d = sticky_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= {WIDTH{1'b0}};
      s1_par_q   <= 1'b0;
      s1_lo_q    <= 1'b0;
      s1_hi_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= {WIDTH{1'b0}};
      s2_err_q   <= 1'b0;
      sticky_q   <= 1'b0;
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_par_q   <= s1_par_d;
      s1_lo_q    <= s1_lo_d;
      s1_hi_q    <= s1_hi_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_err_q   <= s2_err_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_parity_check_pipe.sv
// Directed self-checking bench for parity_check_pipe. A second instance with
// a 2-bit counter shares all inputs and is used for the saturation checks.
module tb_parity_check_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_par;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic        clr_err;
  logic        err_sticky;
  logic [7:0]  err_cnt;

  logic        in_ready2;
  logic        out_valid2;
  logic [31:0] out_data2;
  logic        out_err2;
  logic        err_sticky2;
  logic [1:0]  err_cnt2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  parity_check_pipe #(.WIDTH(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_par(in_par), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .clr_err(clr_err), .err_sticky(err_sticky), .err_cnt(err_cnt)
  );

  parity_check_pipe #(.WIDTH(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_par(in_par), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_err(out_err2),
    .clr_err(clr_err), .err_sticky(err_sticky2), .err_cnt(err_cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] q[$];
  logic [31:0] held;
  logic        prev_stall;
  logic        acc;
  logic        xfer;
  int          fed;
  int          got;
  int          sat_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; in_par = 1'b0;
    out_ready = 1'b1; clr_err = 1'b0;
    tick(); tick();
    // reset state
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_err", out_err, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_sticky", err_sticky, 1'b0);
    chk("rst_cnt", err_cnt, 8'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1'b1);

    // single clean word: visible two cycles after it is presented
    in_valid = 1'b1; in_data = 32'h0000_0000; in_par = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1_not_yet", out_valid, 1'b0);
    tick();
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_data", out_data, 32'h0);
    chk("t1_err", out_err, 1'b0);
    chk("t1_cnt", err_cnt, 8'd0);
    tick();
    chk("t1_drained", out_valid, 1'b0);

    // single-bit error, then a two-ones word with the same stored parity
    in_valid = 1'b1; in_data = 32'h0000_0001; in_par = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t2_valid", out_valid, 1'b1);
    chk("t2_err", out_err, 1'b1);
    tick();
    chk("t2_sticky", err_sticky, 1'b1);
    chk("t2_cnt", err_cnt, 8'd1);
    in_valid = 1'b1; in_data = 32'h8000_0001; in_par = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t2b_err", out_err, 1'b0);
    chk("t2b_data", out_data, 32'h8000_0001);
    tick();
    chk("t2b_cnt", err_cnt, 8'd1);

    // back-to-back stream of 8 words; odd words carry flipped parity
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 8);
      in_data  = 32'hC0DE_0000 | c;
      in_par   = (~(^in_data)) ^ (c % 2 == 1);
      #1;
      chk("t3_in_ready", in_ready, 1'b1);
      tick();
      if (c >= 1 && c <= 8) begin
        chk("t3_valid", out_valid, 1'b1);
        chk("t3_data", out_data, 32'hC0DE_0000 | (c - 1));
        chk("t3_err", out_err, ((c - 1) % 2 == 1));
      end else begin
        chk("t3_idle", out_valid, 1'b0);
      end
    end
    in_valid = 1'b0;
    chk("t3_cnt", err_cnt, 8'd5);
    chk("t3_cnt_sat2", err_cnt2, 2'd3);

    // stream with out_ready low for 3 cycles; scoreboard checks order
    fed = 0; got = 0; prev_stall = 1'b0; held = 32'h0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      in_valid  = (fed < 8);
      in_data   = 32'h5A00_0000 | fed;
      in_par    = ~(^in_data);
      out_ready = !(c >= 3 && c <= 5);
      #1;
      if (c == 4) chk("t4_in_ready_full", in_ready, 1'b0);
      if (prev_stall) chk("t4_hold", out_data, held);
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (xfer) begin
        if (q.size() == 0) chk("t4_dup", 32'd0, 32'd1);
        else begin
          chk("t4_order", out_data, q[0]);
          void'(q.pop_front());
        end
        got++;
      end
      if (acc) begin
        q.push_back(in_data);
        fed++;
      end
      prev_stall = out_valid && !out_ready;
      held = out_data;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("t4_got", got, 8);
    chk("t4_q_empty", q.size(), 0);
    chk("t4_cnt", err_cnt, 8'd5);

    // clear, then saturation of the 2-bit counter
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t5_clr_cnt", err_cnt, 8'd0);
    chk("t5_clr_cnt2", err_cnt2, 2'd0);
    chk("t5_clr_sticky", err_sticky, 1'b0);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 32'h0000_0007; in_par = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("t5_sat_cnt2", err_cnt2, sat_exp[k]);
      chk("t5_cnt", err_cnt, k + 1);
    end

    // clear collides with an erroneous output transfer: clear wins
    in_valid = 1'b1; in_data = 32'h0000_0007; in_par = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t6_err_pending", out_err, 1'b1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t6_cnt", err_cnt, 8'd0);
    chk("t6_sticky", err_sticky, 1'b0);
    chk("t6_cnt2", err_cnt2, 2'd0);
    chk("t6_delivered", out_valid, 1'b0);

    // reset with both stages full
    in_valid = 1'b1; in_data = 32'h0000_0007; in_par = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("t7_cnt_pre", err_cnt, 8'd1);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_par = 1'b0;
    tick();
    in_data = 32'h1234_5678;
    tick();
    in_valid = 1'b0;
    chk("t7_full_valid", out_valid, 1'b1);
    chk("t7_full_in_ready", in_ready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    chk("t7_out_valid", out_valid, 1'b0);
    chk("t7_out_data", out_data, 32'h0);
    chk("t7_out_err", out_err, 1'b0);
    chk("t7_cnt", err_cnt, 8'd0);
    chk("t7_sticky", err_sticky, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t7_no_stale", out_valid, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
